dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported, byte-addressable data memory (1024 bytes, little-endian 32-bit words, synchronous write, combinational read). Port 0 is the core's load/store path. Port 1 is the program-loader/debug port. The block grants one access per cycle using round-robin, supports a bounded bus lock for port 1 bulk loads, range-checks addresses, and returns a registered response one cycle after grant.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_rr_pick.sv | 17 +
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the memories behind it.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        YIELD  = 2'd2
    } arb_state_e;

    localparam int P_CORE     = 0;
    localparam int P_LOAD     = 1;
    localparam int DMEM_BYTES = 1024;

    // A word access is legal only if all four bytes fit below mem_bytes.
    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned mem_bytes);
        logic [31:0] lim;
        lim = 32'(mem_bytes - 4);
        return addr > lim;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module dmem_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory, with a bounded
// port-1 bus lock and a registered response one cycle after each grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = DMEM_BYTES,
    parameter int MAX_LOCK  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_lock,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK);

    arb_state_e       state_q, state_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             last_q, last_d;

    logic [1:0]       req, rr_gnt, gnt, we, oor;
    logic [1:0][31:0] addr, wdata;
    logic [1:0]       rvalid_q, err_q;
    logic [1:0][31:0] rdata_q;

    assign req   = {p1_req, p0_req};
    assign we    = {p1_we, p0_we};
    assign addr  = {p1_addr, p0_addr};
    assign wdata = {p1_wdata, p0_wdata};

    always_comb begin
        oor = '0;
        for (int i = 0; i < 2; i++) oor[i] = addr_oor(addr[i], MEM_BYTES);
    end

    dmem_rr_pick u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = 2'b00;
        unique case (state_q)
            IDLE: begin
                gnt = rr_gnt;
                if (gnt[P_LOAD] && p1_lock) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (p1_lock) begin
                    gnt[P_LOAD] = p1_req;
                    lock_cnt_d  = lock_cnt_q + 1'b1;
                    // Yield as the counter reaches MAX_LOCK-1: together with the
                    // acquiring grant this caps a lock run at MAX_LOCK cycles.
                    if (lock_cnt_d == CW'(MAX_LOCK - 1)) state_d = YIELD;
                end else begin
                    gnt     = rr_gnt;
                    state_d = IDLE;
                end
            end
            YIELD: begin
                if (p0_req)      gnt = 2'b01;
                else if (p1_req) gnt = 2'b10;
                lock_cnt_d = '0;
                state_d    = p1_lock ? LOCKED : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) gnt = 2'b00;
    end

    always_comb begin
        last_d = last_q;
        if (gnt[P_LOAD])      last_d = 1'b1;
        else if (gnt[P_CORE]) last_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
        end
    end

    // Out-of-range accesses are granted but never reach the memory.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                mem_read  = !we[i] && !oor[i];
                mem_write = we[i] && !oor[i];
                mem_addr  = addr[i];
                mem_wdata = wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt & oor;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) rdata_q[i] <= (!we[i] && !oor[i]) ? mem_rdata : '0;
            end
        end
    end

    assign p0_gnt    = gnt[P_CORE];
    assign p1_gnt    = gnt[P_LOAD];
    assign p0_rvalid = rvalid_q[P_CORE];
    assign p1_rvalid = rvalid_q[P_LOAD];
    assign p0_err    = err_q[P_CORE];
    assign p1_err    = err_q[P_LOAD];
    assign p0_rdata  = rdata_q[P_CORE];
    assign p1_rdata  = rdata_q[P_LOAD];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued at grant time
// and compared when rvalid appears; directed grant patterns are checked inline.
module tb_dmem_arbiter;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    rsp_t        q0[$], q1[$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(1024), .MAX_LOCK(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_err(p0_err), .p1_err(p1_err),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    assign mem_rdata = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                        mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};

    // Bench-side memory: one process owns it.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_write)
                for (int b = 0; b < 4; b++) mem[mem_addr[9:0] + 10'(b)] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
    endfunction

    task automatic expect_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 output rsp_t r);
        logic oor;
        oor = (a > 32'd1020);
        chk("mem_read", mem_read, !we && !oor);
        chk("mem_write", mem_write, we && !oor);
        chk("mem_addr", mem_addr, a);
        if (we) chk("mem_wdata", mem_wdata, wd);
        r.err   = oor;
        r.rdata = (!we && !oor) ? ref_word(a) : 32'd0;
        if (we && !oor)
            for (int b = 0; b < 4; b++) ref_mem[a[9:0] + 10'(b)] = wd[8*b +: 8];
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        rsp_t e;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                pend0 = 1'b0;
                pend1 = 1'b0;
                q0.delete();
                q1.delete();
            end else begin
                chk("p0_rvalid", p0_rvalid, pend0);
                chk("p1_rvalid", p1_rvalid, pend1);
                if (pend0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("p0_rdata", p0_rdata, e.rdata);
                    chk("p0_err", p0_err, e.err);
                end
                if (pend1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("p1_rdata", p1_rdata, e.rdata);
                    chk("p1_err", p1_err, e.err);
                end
                chk("gnt_onehot", p0_gnt & p1_gnt, 0);
                pend0 = p0_gnt;
                pend1 = p1_gnt;
                if (p0_gnt) begin
                    expect_access(p0_we, p0_addr, p0_wdata, e);
                    q0.push_back(e);
                end else if (p1_gnt) begin
                    expect_access(p1_we, p1_addr, p1_wdata, e);
                    q1.push_back(e);
                end else begin
                    chk("idle_strobes", {mem_read, mem_write}, 0);
                    chk("idle_addr", mem_addr, 0);
                end
            end
        end
    end

    task automatic set_p0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic lock);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_lock = lock;
    endtask

    // Check the grant vector of the current cycle, then move to just after the edge.
    task automatic gnt_cyc(input string tag, input logic [1:0] exp);
        @(negedge clk);
        chk(tag, {p1_gnt, p0_gnt}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        p0_req = 1'b1;
        #1;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
        chk("rst_err", {p1_err, p0_err}, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        p0_req = 1'b0;
        rst = 1'b0;

        // Single-port write then read back.
        set_p0(1, 1, 32'h10, 32'hDEADBEEF);
        gnt_cyc("t1_wr_gnt", 2'b01);
        set_p0(1, 0, 32'h10, 0);
        gnt_cyc("t1_rd_gnt", 2'b01);
        set_p0(0, 0, 0, 0);
        @(negedge clk);
        chk("t1_rvalid", p0_rvalid, 1);
        chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
        chk("t1_err", p0_err, 0);
        @(posedge clk);
        #1;

        // Both ports reading continuously from reset: 0,1,0,1...
        pulse_reset();
        set_p0(1, 0, 32'h20, 0);
        set_p1(1, 0, 32'h40, 0, 0);
        for (int k = 0; k < 8; k++) gnt_cyc("t2_rr", (k % 2) ? 2'b10 : 2'b01);

        // Lock: after the tie goes to p0, p1 holds 16 cycles (acquire + 15),
        // then every run is one p0 yield slot plus 15 locked p1 grants.
        pulse_reset();
        set_p0(1, 0, 32'h20, 0);
        set_p1(1, 1, 32'h100, 32'hA5A50001, 1);
        gnt_cyc("t3_tie", 2'b01);
        for (int k = 0; k < 16; k++) gnt_cyc("t3_lock_a", 2'b10);
        gnt_cyc("t3_yield_a", 2'b01);
        for (int k = 0; k < 15; k++) gnt_cyc("t3_lock_b", 2'b10);
        gnt_cyc("t3_yield_b", 2'b01);

        // Drop the lock mid-run: round-robin resumes in that same cycle.
        for (int k = 0; k < 3; k++) gnt_cyc("t4_locked", 2'b10);
        set_p1(1, 0, 32'h104, 0, 0);
        gnt_cyc("t4_unlock", 2'b01);
        gnt_cyc("t4_rr_a", 2'b10);
        gnt_cyc("t4_rr_b", 2'b01);

        // Range checks at and beyond the last legal word.
        set_p1(0, 0, 0, 0, 0);
        set_p0(1, 0, 32'h3FD, 0);
        @(negedge clk);
        chk("t5_gnt", p0_gnt, 1);
        chk("t5_mem_read", mem_read, 0);
        @(posedge clk);
        #1;
        set_p0(1, 1, 32'h3FD, 32'h12345678);
        @(negedge clk);
        chk("t5_oor_rsp_err", p0_err, 1);
        chk("t5_oor_rsp_rdata", p0_rdata, 0);
        chk("t5_mem_write", mem_write, 0);
        @(posedge clk);
        #1;
        set_p0(1, 0, 32'h3FC, 0);
        gnt_cyc("t5_edge_gnt", 2'b01);
        set_p0(1, 0, 32'hFFFF_FFFC, 0);
        @(negedge clk);
        chk("t5_edge_err", p0_err, 0);
        chk("t5_edge_rdata", p0_rdata, {pat(1023), pat(1022), pat(1021), pat(1020)});
        @(posedge clk);
        #1;
        set_p0(0, 0, 0, 0);
        @(negedge clk);
        chk("t5_wrap_err", p0_err, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a lock with an error response outstanding.
        pulse_reset();
        set_p1(1, 0, 32'h400, 0, 1);
        gnt_cyc("t6_acquire", 2'b10);
        gnt_cyc("t6_locked", 2'b10);
        chk("t6_pre_rvalid", p1_rvalid, 1);
        chk("t6_pre_err", p1_err, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", p1_rvalid, 0);
        chk("t6_rst_err", p1_err, 0);
        chk("t6_rst_gnt", p1_gnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_p0(1, 0, 32'h30, 0);
        set_p1(1, 0, 32'h34, 0, 0);
        gnt_cyc("t6_first_tie", 2'b01);
        gnt_cyc("t6_second", 2'b10);
        set_p0(0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
